// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the MIPS hazard scoreboard: opcode/funct constants,
// Tuse/Tnew encodings, the scoreboard entry layout and the decode classes.
package hzd_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // REGIMM rt-field branch selectors
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  // Tuse/Tnew are 2-bit cycle counts; Tuse 3 marks an unused source
  typedef logic [1:0] tcnt_t;
  localparam tcnt_t T_NONE = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    tcnt_t      tnew;
  } sb_entry_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_CALR, CL_SHIFT, CL_CALI, CL_LUI, CL_LOAD, CL_STORE,
    CL_BR2, CL_BR1, CL_JAL, CL_JR, CL_JALR, CL_MD, CL_MF, CL_MT
  } instr_class_e;

  typedef enum logic {MD_MULT, MD_DIV} md_kind_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bus: instruction in, stall/forward/busy out.
interface hazard_scoreboard_if #(
  parameter int STAGES = 3
);
  localparam int FW = $clog2(STAGES + 1);

  logic [31:0]   instr_d;
  logic          valid_d;
  logic          stall;
  logic [FW-1:0] fwd_rs_d;
  logic [FW-1:0] fwd_rt_d;
  logic          md_busy;

  modport master (
    output instr_d, valid_d,
    input  stall, fwd_rs_d, fwd_rt_d, md_busy
  );

  modport slave (
    input  instr_d, valid_d,
    output stall, fwd_rs_d, fwd_rt_d, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard_decode.sv
// Combinational D-stage decoder: instruction -> sources, destination,
// Tuse/Tnew and multiply/divide usage.
module hzd_decode
  import hzd_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_dst,
  output tcnt_t       o_tuse_rs,
  output tcnt_t       o_tuse_rt,
  output tcnt_t       o_tnew,
  output logic        o_md_start,
  output md_kind_e    o_md_kind,
  output logic        o_md_use
);

  logic [5:0]   w_op;
  logic [5:0]   w_funct;
  logic [4:0]   w_rd;
  instr_class_e w_cls;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];
  assign w_rd    = i_instr[15:11];
  assign o_rs    = i_instr[25:21];
  assign o_rt    = i_instr[20:16];

  // Classify the instruction; the all-zero word is the canonical nop
  always_comb begin
    w_cls = CL_NONE;
    case (w_op)
      OP_SPECIAL: begin
        case (w_funct)
          F_SLL, F_SRL, F_SRA:                     w_cls = CL_SHIFT;
          F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU:             w_cls = CL_CALR;
          F_JR:                                    w_cls = CL_JR;
          F_JALR:                                  w_cls = CL_JALR;
          F_MFHI, F_MFLO:                          w_cls = CL_MF;
          F_MTHI, F_MTLO:                          w_cls = CL_MT;
          F_MULT, F_MULTU, F_DIV, F_DIVU:          w_cls = CL_MD;
          default:                                 w_cls = CL_NONE;
        endcase
      end
      OP_REGIMM: w_cls = (o_rt == RT_BLTZ || o_rt == RT_BGEZ) ? CL_BR1 : CL_NONE;
      OP_BEQ, OP_BNE:                              w_cls = CL_BR2;
      OP_BLEZ, OP_BGTZ:                            w_cls = CL_BR1;
      OP_JAL:                                      w_cls = CL_JAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI:                    w_cls = CL_CALI;
      OP_LUI:                                      w_cls = CL_LUI;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:         w_cls = CL_LOAD;
      OP_SB, OP_SH, OP_SW:                         w_cls = CL_STORE;
      default:                                     w_cls = CL_NONE;
    endcase
    if (i_instr == 32'h0) w_cls = CL_NONE;
  end

  // Map the class onto register-use deadlines and result-ready times
  always_comb begin
    o_dst      = 5'd0;
    o_tnew     = 2'd0;
    o_tuse_rs  = T_NONE;
    o_tuse_rt  = T_NONE;
    o_md_start = 1'b0;
    o_md_use   = 1'b0;
    o_md_kind  = (w_funct == F_DIV || w_funct == F_DIVU) ? MD_DIV : MD_MULT;
    case (w_cls)
      CL_CALR:  begin o_dst = w_rd; o_tnew = 2'd1; o_tuse_rs = 2'd1; o_tuse_rt = 2'd1; end
      CL_SHIFT: begin o_dst = w_rd; o_tnew = 2'd1; o_tuse_rt = 2'd1; end
      CL_CALI:  begin o_dst = o_rt; o_tnew = 2'd1; o_tuse_rs = 2'd1; end
      CL_LUI:   begin o_dst = o_rt; o_tnew = 2'd1; end
      CL_LOAD:  begin o_dst = o_rt; o_tnew = 2'd2; o_tuse_rs = 2'd1; end
      CL_STORE: begin o_tuse_rs = 2'd1; o_tuse_rt = 2'd2; end
      CL_BR2:   begin o_tuse_rs = 2'd0; o_tuse_rt = 2'd0; end
      CL_BR1:   begin o_tuse_rs = 2'd0; end
      CL_JAL:   begin o_dst = 5'd31; o_tnew = 2'd0; end
      CL_JR:    begin o_tuse_rs = 2'd0; end
      CL_JALR:  begin o_dst = w_rd; o_tnew = 2'd0; o_tuse_rs = 2'd0; end
      CL_MD:    begin o_tuse_rs = 2'd1; o_tuse_rt = 2'd1; o_md_start = 1'b1; o_md_use = 1'b1; end
      CL_MF:    begin o_dst = w_rd; o_tnew = 2'd1; o_md_use = 1'b1; end
      CL_MT:    begin o_tuse_rs = 2'd1; o_md_use = 1'b1; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall and forward controller for the five-stage MIPS pipeline: a shift
// register scoreboard of in-flight producers plus a multiply/divide busy
// counter, compared against the decoded D-stage instruction.
module hazard_scoreboard
  import hzd_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic                clk,
  input logic                reset_n,
  hazard_scoreboard_if.slave bus
);

  localparam int FW    = $clog2(STAGES + 1);
  localparam int MDMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MDMAX + 1);

  logic [4:0]    w_rs, w_rt, w_dst;
  tcnt_t         w_tuse_rs, w_tuse_rt, w_tnew;
  logic          w_md_start, w_md_use;
  md_kind_e      w_md_kind;

  logic          w_data_stall, w_md_stall, w_stall, w_issue, w_md_busy;
  logic [FW-1:0] w_fwd_rs, w_fwd_rt;

  // Entry 1 is E; higher indices are older producers
  sb_entry_t     r_sb [1:STAGES];
  logic          r_md_e1;
  logic [CW-1:0] r_md_cnt;

  hzd_decode u_decode (
    .i_instr    (bus.instr_d),
    .o_rs       (w_rs),
    .o_rt       (w_rt),
    .o_dst      (w_dst),
    .o_tuse_rs  (w_tuse_rs),
    .o_tuse_rt  (w_tuse_rt),
    .o_tnew     (w_tnew),
    .o_md_start (w_md_start),
    .o_md_kind  (w_md_kind),
    .o_md_use   (w_md_use)
  );

  // Compare D sources against every in-flight producer; scanning oldest
  // to youngest lets the youngest ready match win the forward select
  always_comb begin
    w_data_stall = 1'b0;
    w_fwd_rs     = '0;
    w_fwd_rt     = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (r_sb[k].valid && r_sb[k].dst == w_rs && w_tuse_rs != T_NONE) begin
        if (r_sb[k].tnew > w_tuse_rs) w_data_stall = 1'b1;
        if (r_sb[k].tnew == 2'd0)     w_fwd_rs     = FW'(k);
      end
      if (r_sb[k].valid && r_sb[k].dst == w_rt && w_tuse_rt != T_NONE) begin
        if (r_sb[k].tnew > w_tuse_rt) w_data_stall = 1'b1;
        if (r_sb[k].tnew == 2'd0)     w_fwd_rt     = FW'(k);
      end
    end
  end

  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_stall = w_md_use && (w_md_busy || r_md_e1);
  assign w_stall    = bus.valid_d && (w_data_stall || w_md_stall);
  assign w_issue    = bus.valid_d && !w_stall;

  assign bus.stall    = w_stall;
  assign bus.fwd_rs_d = w_fwd_rs;
  assign bus.fwd_rt_d = w_fwd_rt;
  assign bus.md_busy  = w_md_busy;

  // Advance the scoreboard: issue or bubble into E, age older entries
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= STAGES; k++) r_sb[k] <= '0;
      r_md_e1 <= 1'b0;
    end else begin
      r_sb[1].valid <= w_issue && (w_dst != 5'd0);
      r_sb[1].dst   <= w_dst;
      r_sb[1].tnew  <= w_tnew;
      r_md_e1       <= w_issue && w_md_start;
      for (int k = 2; k <= STAGES; k++) begin
        r_sb[k].valid <= r_sb[k-1].valid;
        r_sb[k].dst   <= r_sb[k-1].dst;
        r_sb[k].tnew  <= (r_sb[k-1].tnew == 2'd0) ? 2'd0 : r_sb[k-1].tnew - 2'd1;
      end
    end
  end

  // Multiply/divide busy counter; a new start overrides any count in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_md_cnt <= '0;
    end else if (w_issue && w_md_start) begin
      r_md_cnt <= (w_md_kind == MD_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (STAGES=3, MULT=5, DIV=10).
module tb_hazard_scoreboard;

  localparam int FW = 2;

  logic clk;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  hazard_scoreboard_if #(.STAGES(3)) bus ();

  hazard_scoreboard #(.STAGES(3), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic set_d(input logic [31:0] ins, input logic vld);
    bus.instr_d = ins;
    bus.valid_d = vld;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubbles(input int n);
    bus.instr_d = 32'h0;
    bus.valid_d = 1'b0;
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic es, input logic [FW-1:0] ers,
                     input logic [FW-1:0] ert, input logic eb);
    n_assert++;
    assert (bus.stall === es) else begin
      n_fail++;
      $error("FAIL %s stall: observed %0b expected %0b", tag, bus.stall, es);
    end
    n_assert++;
    assert (bus.fwd_rs_d === ers) else begin
      n_fail++;
      $error("FAIL %s fwd_rs: observed %0d expected %0d", tag, bus.fwd_rs_d, ers);
    end
    n_assert++;
    assert (bus.fwd_rt_d === ert) else begin
      n_fail++;
      $error("FAIL %s fwd_rt: observed %0d expected %0d", tag, bus.fwd_rt_d, ert);
    end
    n_assert++;
    assert (bus.md_busy === eb) else begin
      n_fail++;
      $error("FAIL %s md_busy: observed %0b expected %0b", tag, bus.md_busy, eb);
    end
  endtask

  logic [31:0] LW1, ADDU213, ADDU412, ADDU123, BEQ14, ORI0, BEQ00, JAL, JR31;
  logic [31:0] MULT12, DIV12, MFLO3, LW5, ADDU650;

  initial begin
    LW1     = i_ins(6'h23, 0, 1, 16'h0);
    ADDU213 = r_ins(1, 3, 2, 6'h21);
    ADDU412 = r_ins(1, 2, 4, 6'h21);
    ADDU123 = r_ins(2, 3, 1, 6'h21);
    BEQ14   = i_ins(6'h04, 1, 4, 16'h0);
    ORI0    = i_ins(6'h0D, 0, 0, 16'h5);
    BEQ00   = i_ins(6'h04, 0, 0, 16'h0);
    JAL     = {6'h03, 26'h10};
    JR31    = r_ins(31, 0, 0, 6'h08);
    MULT12  = r_ins(1, 2, 0, 6'h18);
    DIV12   = r_ins(1, 2, 0, 6'h1A);
    MFLO3   = r_ins(0, 0, 3, 6'h12);
    LW5     = i_ins(6'h23, 0, 5, 16'h0);
    ADDU650 = r_ins(5, 0, 6, 6'h21);

    // reset state, with a real instruction presented in D
    reset_n = 1'b0;
    bus.instr_d = MFLO3;
    bus.valid_d = 1'b1;
    #12;
    chk("reset", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    bubbles(1);

    // load-use: exactly one stall cycle, then lw is in M
    set_d(LW1, 1'b1);      chk("lu_lw", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(ADDU213, 1'b0);  chk("lu_novalid", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(ADDU213, 1'b1);  chk("lu_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(ADDU213, 1'b1);  chk("lu_release", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(ADDU412, 1'b1);  chk("lu_fwd_w", 1'b0, 2'd3, 2'd0, 1'b0);
    bubbles(3);

    // ALU result feeding a branch: one stall, then forward from M
    set_d(ADDU123, 1'b1);  chk("br_alu", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(BEQ14, 1'b1);    chk("br_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(BEQ14, 1'b1);    chk("br_fwd_m", 1'b0, 2'd2, 2'd0, 1'b0);
    bubbles(3);

    // writes to $0 never hazard or forward
    set_d(ORI0, 1'b1);     chk("r0_ori", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(BEQ00, 1'b1);    chk("r0_beq1", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(BEQ00, 1'b1);    chk("r0_beq2", 1'b0, 2'd0, 2'd0, 1'b0);
    bubbles(3);

    // jal then jr $31 forwards from E without stalling
    set_d(JAL, 1'b1);      chk("jal", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(JR31, 1'b1);     chk("jr_fwd_e", 1'b0, 2'd1, 2'd0, 1'b0);
    bubbles(3);

    // two ready producers of $31: the youngest (E) wins
    set_d(JAL, 1'b1);      chk("jal_a", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(JAL, 1'b1);      chk("jal_b", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(JR31, 1'b1);     chk("jr_youngest", 1'b0, 2'd1, 2'd0, 1'b0);
    bubbles(3);

    // mult then mflo: exactly 5 stall cycles
    set_d(MULT12, 1'b1);   chk("mult", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_d(MFLO3, 1'b1);  chk($sformatf("mult_stall%0d", i), 1'b1, 2'd0, 2'd0, 1'b1);
      tick();
    end
    set_d(MFLO3, 1'b1);    chk("mult_done", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    bubbles(3);

    // div then mflo: exactly 10 stall cycles
    set_d(DIV12, 1'b1);    chk("div", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_d(MFLO3, 1'b1);  chk($sformatf("div_stall%0d", i), 1'b1, 2'd0, 2'd0, 1'b1);
      tick();
    end
    set_d(MFLO3, 1'b1);    chk("div_done", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    bubbles(3);

    // reset while div is busy and a load-use stall is pending
    set_d(DIV12, 1'b1);    chk("rst_div", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();
    set_d(LW5, 1'b1);      chk("rst_lw", 1'b0, 2'd0, 2'd0, 1'b1);
    tick();
    set_d(ADDU650, 1'b1);  chk("rst_pending", 1'b1, 2'd0, 2'd0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_async", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    set_d(MFLO3, 1'b1);    chk("rst_mflo", 1'b0, 2'd0, 2'd0, 1'b0);
    set_d(ADDU650, 1'b1);  chk("rst_addu", 1'b0, 2'd0, 2'd0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
